// File: rtl/key_code_buffer_if.sv
// Scanner handshake and consumer-side FIFO signals for key_code_buffer.
// The slave modport is the buffer; the master modport drives scanner and consumer inputs.
interface key_code_buffer_if;
    logic [3:0] RowColVector;
    logic       KeyRdy;
    logic       KeyRd;
    logic       Clear;
    logic       KeyPop;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic [3:0] Count;
    logic       Full;

    modport slave (
        input  RowColVector, KeyRdy, Clear, KeyPop,
        output KeyRd, KeyCode, KeyValid, Count, Full
    );

    modport master (
        output RowColVector, KeyRdy, Clear, KeyPop,
        input  KeyRd, KeyCode, KeyValid, Count, Full
    );
endinterface

// File: rtl/key_code_buffer.sv
// Keypad code buffer: translates scanner row/column positions into key codes and
// queues them in a show-ahead FIFO, with a two-state KeyRdy/KeyRd handshake.
module key_code_buffer #(
    parameter int DEPTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    key_code_buffer_if.slave  kb
);
    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           key_rd_q, key_rd_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]     count_q, count_d;
    logic           valid_q, valid_d;
    logic           full_q, full_d;
    logic [3:0]     key_code_q, key_code_d;
    logic [3:0]     mem_q [DEPTH];
    logic           wr_en_s;
    logic           pop_s;
    logic [3:0]     wr_code_s;

    // Layout rows: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D"; * and # map to E and F.
    function automatic logic [3:0] xlate(input logic [3:0] rc);
        logic [3:0] code;
        case (rc)
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Next-state logic for handshake FSM, pointers, count and the registered head.
    always_comb begin
        state_d    = state_q;
        key_rd_d   = key_rd_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wr_code_s  = xlate(kb.RowColVector);
        // Full is the registered value, so a same-edge pop never opens room for a write.
        wr_en_s    = (state_q == IDLE) && kb.KeyRdy && !full_q && !kb.Clear;
        pop_s      = kb.KeyPop && valid_q && !kb.Clear;

        case (state_q)
            IDLE: begin
                if (wr_en_s) begin
                    state_d  = ACK;
                    key_rd_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    key_rd_d = 1'b0;
                end
            end
            ACK: begin
                if (!kb.KeyRdy) begin
                    state_d  = IDLE;
                    key_rd_d = 1'b0;
                end else begin
                    state_d  = ACK;
                    key_rd_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                key_rd_d = 1'b0;
            end
        endcase

        if (kb.Clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end

        valid_d = (count_d != 4'd0);
        full_d  = (count_d == DEPTH_C);

        // The new head is the incoming code when it lands exactly where the read pointer goes.
        if (!valid_d) begin
            key_code_d = 4'h0;
        end else if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
            key_code_d = wr_code_s;
        end else begin
            key_code_d = mem_q[rd_ptr_d];
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            key_rd_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            key_code_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            key_rd_q   <= key_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            key_code_q <= key_code_d;
        end
    end

    // FIFO storage; contents are hidden behind KeyCode=0 whenever the buffer is empty.
    always_ff @(posedge Clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_code_s;
        end
    end

    assign kb.KeyRd    = key_rd_q;
    assign kb.KeyCode  = key_code_q;
    assign kb.KeyValid = valid_q;
    assign kb.Count    = count_q;
    assign kb.Full     = full_q;
endmodule
